// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the parametrised synchronous FIFO.
//   ptr_w()     : pointer/count width for a given depth. One extra bit above
//                 the address bits lets full and empty be told apart.
//   params_ok() : elaboration-time legality check of the FIFO parameters.
// -----------------------------------------------------------------------------
package fifo_pkg;

   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Legal when DATA_W >= 1, DEPTH is a power of two >= 2,
   // AFULL_TH in 1..DEPTH and AEMPTY_TH in 0..DEPTH-1.
   function automatic bit params_ok(input int data_w,
                                    input int depth,
                                    input int afull_th,
                                    input int aempty_th);
      return (data_w >= 1) &&
             (depth >= 2) && ((depth & (depth - 1)) == 0) &&
             (afull_th >= 1) && (afull_th <= depth) &&
             (aempty_th >= 0) && (aempty_th <= depth - 1);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Simple dual-port RAM, DEPTH x DATA_W. Synchronous write, registered
// synchronous read, no reset on the array or on the read register.
// A read and a write to the same address on the same edge return the
// previous contents (read-before-write).
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_re     in   read enable (read register loads only when set)
//   i_raddr  in   read address
//   o_rdata  out  registered read data
// -----------------------------------------------------------------------------
module fifo_mem #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [AW-1:0]     i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/param_sync_fifo.sv
// -----------------------------------------------------------------------------
// param_sync_fifo
// Parametrised single-clock FIFO with registered read port, occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   wr_en/wr_data in   write request and data
//   rd_en         in   read request
//   rd_data       out  read data, valid when rd_valid=1, holds otherwise
//   rd_valid      out  one-cycle strobe per accepted read
//   full/empty    out  count == DEPTH / count == 0
//   almost_full   out  count >= AFULL_TH
//   almost_empty  out  count <= AEMPTY_TH
//   count         out  occupancy 0..DEPTH
//   overflow      out  sticky: a write was rejected
//   underflow     out  sticky: a read was rejected
//   err_clr       in   clears overflow/underflow (a new event wins)
//
// Handshake: a read is accepted when rd_en=1 and the FIFO is not empty; its
// word appears on rd_data with rd_valid=1 after the next edge. A write is
// accepted when wr_en=1 and the FIFO is not full, or is full but a read is
// accepted in the same cycle. A request that is not accepted is dropped and
// raises the matching sticky error flag. There is no read bypass: an empty
// FIFO rejects rd_en even while a write is being accepted.
// -----------------------------------------------------------------------------
module param_sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 8,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [DATA_W-1:0]         wr_data,
   input  logic                      rd_en,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      rd_valid,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [ptr_w(DEPTH)-1:0]   count,
   output logic                      overflow,
   output logic                      underflow,
   input  logic                      err_clr
);

   localparam int CW = ptr_w(DEPTH);
   localparam int AW = CW - 1;

   if (!params_ok(DATA_W, DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
      $error("param_sync_fifo: illegal DATA_W/DEPTH/AFULL_TH/AEMPTY_TH");
   end

   logic [CW-1:0]     r_wr_ptr;
   logic [CW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_rd_valid;
   logic              r_overflow;
   logic              r_underflow;
   logic              r_rd_seen;

   logic              w_empty;
   logic              w_full;
   logic              w_do_rd;
   logic              w_do_wr;
   logic [DATA_W-1:0] w_mem_rdata;

   // Flags decode from the count register only, so no input reaches them
   // combinationally.
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));

   assign w_do_rd = rd_en & ~w_empty;
   assign w_do_wr = wr_en & (~w_full | w_do_rd);

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_do_wr & ~rst),
      .i_waddr (r_wr_ptr[AW-1:0]),
      .i_wdata (wr_data),
      .i_re    (w_do_rd & ~rst),
      .i_raddr (r_rd_ptr[AW-1:0]),
      .o_rdata (w_mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_rd_valid  <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_rd_seen   <= 1'b0;
      end else begin
         if (w_do_wr) begin
            r_wr_ptr <= r_wr_ptr + CW'(1);
         end
         if (w_do_rd) begin
            r_rd_ptr  <= r_rd_ptr + CW'(1);
            r_rd_seen <= 1'b1;
         end
         case ({w_do_wr, w_do_rd})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         r_rd_valid <= w_do_rd;
         // A new error event takes priority over a clear in the same cycle.
         if (wr_en & ~w_do_wr) begin
            r_overflow <= 1'b1;
         end else if (err_clr) begin
            r_overflow <= 1'b0;
         end
         if (rd_en & ~w_do_rd) begin
            r_underflow <= 1'b1;
         end else if (err_clr) begin
            r_underflow <= 1'b0;
         end
      end
   end

   // The RAM read register has no reset; until the first accepted read after
   // reset it may hold stale or unknown data, so present zero instead.
   assign rd_data      = r_rd_seen ? w_mem_rdata : '0;
   assign rd_valid     = r_rd_valid;
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= CW'(AFULL_TH));
   assign almost_empty = (r_count <= CW'(AEMPTY_TH));
   assign count        = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

   // Occupancy must always equal the pointer distance.
   a_count_matches_ptrs: assert property (
      @(posedge clk) disable iff (rst) r_count == (r_wr_ptr - r_rd_ptr));

endmodule

// File: tb/tb_param_sync_fifo.sv
module tb_param_sync_fifo;

   localparam int DW = 32;
   localparam int DP = 8;

   logic          clk;
   logic          rst;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          rd_en;
   logic          err_clr;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [3:0]    count;
   logic          overflow;
   logic          underflow;

   int n_checks = 0;
   int n_pass   = 0;

   // bench model of contents and sticky flags
   logic [DW-1:0] model_q[$];
   logic [DW-1:0] exp_q[$];
   logic          m_ovf;
   logic          m_unf;
   logic          m_rd_valid;
   logic [DW-1:0] last_rd;

   param_sync_fifo #(
      .DATA_W    (DW),
      .DEPTH     (DP),
      .AFULL_TH  (6),
      .AEMPTY_TH (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow),
      .err_clr      (err_clr)
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // scoreboard: every rd_valid strobe must match the oldest expected word
   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected_rd: got rd_valid=1 data=%h, required no read", rd_data);
         end else begin
            if (rd_data !== exp_q[0]) begin
               $display("FAIL sb_rd_data: got %h required %h", rd_data, exp_q[0]);
            end else begin
               n_pass++;
            end
            void'(exp_q.pop_front());
         end
      end
   end

   // driver tasks
   task automatic drive(input logic wr, input logic [DW-1:0] d, input logic rd, input logic clr);
      logic do_rd;
      logic do_wr;
      wr_en   = wr;
      wr_data = d;
      rd_en   = rd;
      err_clr = clr;
      do_rd = rd && (model_q.size() > 0);
      do_wr = wr && ((model_q.size() < DP) || do_rd);
      if (do_rd) begin
         last_rd = model_q.pop_front();
         exp_q.push_back(last_rd);
      end
      if (do_wr) model_q.push_back(d);
      if (wr && !do_wr) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (rd && !do_rd) m_unf = 1'b1;
      else if (clr) m_unf = 1'b0;
      m_rd_valid = do_rd;
      @(posedge clk);
      #1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      err_clr = 1'b0;
   endtask

   task automatic do_reset(input logic wr, input logic rd);
      rst     = 1'b1;
      wr_en   = wr;
      rd_en   = rd;
      wr_data = 32'hDEAD_BEEF;
      err_clr = 1'b0;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      model_q.delete();
      exp_q.delete();
      m_ovf      = 1'b0;
      m_unf      = 1'b0;
      m_rd_valid = 1'b0;
      last_rd    = '0;
   endtask

   task automatic test_reset();
      do_reset(1'b1, 1'b1);
      n_checks++; if (count !== 4'd0) $display("FAIL rst_count: got %0d required 0", count); else n_pass++;
      n_checks++; if (empty !== 1'b1) $display("FAIL rst_empty: got %b required 1", empty); else n_pass++;
      n_checks++; if (full !== 1'b0) $display("FAIL rst_full: got %b required 0", full); else n_pass++;
      n_checks++; if (almost_empty !== 1'b1) $display("FAIL rst_aempty: got %b required 1", almost_empty); else n_pass++;
      n_checks++; if (almost_full !== 1'b0) $display("FAIL rst_afull: got %b required 0", almost_full); else n_pass++;
      n_checks++; if (rd_valid !== 1'b0) $display("FAIL rst_rd_valid: got %b required 0", rd_valid); else n_pass++;
      n_checks++; if (rd_data !== 32'h0) $display("FAIL rst_rd_data: got %h required 0", rd_data); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b required 0", overflow); else n_pass++;
      n_checks++; if (underflow !== 1'b0) $display("FAIL rst_underflow: got %b required 0", underflow); else n_pass++;
   endtask

   task automatic test_fill();
      for (int i = 0; i < DP; i++) begin
         drive(1'b1, 32'hA0 + i, 1'b0, 1'b0);
         n_checks++; if (count !== 4'(i + 1)) $display("FAIL fill_count[%0d]: got %0d required %0d", i, count, i + 1); else n_pass++;
         n_checks++; if (almost_full !== (i + 1 >= 6)) $display("FAIL fill_afull[%0d]: got %b", i, almost_full); else n_pass++;
         n_checks++; if (full !== (i + 1 == DP)) $display("FAIL fill_full[%0d]: got %b", i, full); else n_pass++;
         n_checks++; if (almost_empty !== (i + 1 <= 2)) $display("FAIL fill_aempty[%0d]: got %b", i, almost_empty); else n_pass++;
         n_checks++; if (empty !== 1'b0) $display("FAIL fill_empty[%0d]: got %b required 0", i, empty); else n_pass++;
      end
      drive(1'b1, 32'hFF, 1'b0, 1'b0);
      n_checks++; if (overflow !== 1'b1) $display("FAIL fill_overflow: got %b required 1", overflow); else n_pass++;
      n_checks++; if (count !== 4'd8) $display("FAIL fill_count_after_ovf: got %0d required 8", count); else n_pass++;
      n_checks++; if (underflow !== 1'b0) $display("FAIL fill_underflow: got %b required 0", underflow); else n_pass++;
      drive(1'b0, '0, 1'b0, 1'b1);
      n_checks++; if (overflow !== 1'b0) $display("FAIL fill_ovf_clear: got %b required 0", overflow); else n_pass++;
   endtask

   task automatic test_drain();
      for (int i = 0; i < DP; i++) begin
         drive(1'b0, '0, 1'b1, 1'b0);
         n_checks++; if (rd_valid !== 1'b1) $display("FAIL drain_rd_valid[%0d]: got %b required 1", i, rd_valid); else n_pass++;
         n_checks++; if (count !== 4'(DP - 1 - i)) $display("FAIL drain_count[%0d]: got %0d required %0d", i, count, DP - 1 - i); else n_pass++;
      end
      n_checks++; if (empty !== 1'b1) $display("FAIL drain_empty: got %b required 1", empty); else n_pass++;
      drive(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (rd_valid !== 1'b0) $display("FAIL drain_extra_rd_valid: got %b required 0", rd_valid); else n_pass++;
      n_checks++; if (underflow !== 1'b1) $display("FAIL drain_underflow: got %b required 1", underflow); else n_pass++;
      drive(1'b0, '0, 1'b0, 1'b0);
      n_checks++; if (rd_data !== last_rd) $display("FAIL drain_rd_hold: got %h required %h", rd_data, last_rd); else n_pass++;
      drive(1'b0, '0, 1'b0, 1'b1);
      n_checks++; if (underflow !== 1'b0) $display("FAIL drain_unf_clear: got %b required 0", underflow); else n_pass++;
   endtask

   task automatic test_full_rw();
      for (int i = 0; i < DP; i++) drive(1'b1, 32'hB0 + i, 1'b0, 1'b0);
      drive(1'b1, 32'h55, 1'b1, 1'b0);
      n_checks++; if (count !== 4'd8) $display("FAIL full_rw_count: got %0d required 8", count); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL full_rw_overflow: got %b required 0", overflow); else n_pass++;
      n_checks++; if (rd_valid !== 1'b1) $display("FAIL full_rw_rd_valid: got %b required 1", rd_valid); else n_pass++;
      for (int i = 0; i < DP; i++) drive(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (empty !== 1'b1) $display("FAIL full_rw_empty: got %b required 1", empty); else n_pass++;
   endtask

   task automatic test_empty_rw();
      drive(1'b1, 32'h11, 1'b1, 1'b0);
      n_checks++; if (count !== 4'd1) $display("FAIL empty_rw_count: got %0d required 1", count); else n_pass++;
      n_checks++; if (rd_valid !== 1'b0) $display("FAIL empty_rw_rd_valid: got %b required 0", rd_valid); else n_pass++;
      n_checks++; if (underflow !== 1'b1) $display("FAIL empty_rw_underflow: got %b required 1", underflow); else n_pass++;
      drive(1'b0, '0, 1'b1, 1'b1);
      n_checks++; if (rd_valid !== 1'b1) $display("FAIL empty_rw_next_rd: got %b required 1", rd_valid); else n_pass++;
      n_checks++; if (underflow !== 1'b0) $display("FAIL empty_rw_unf_clear: got %b required 0", underflow); else n_pass++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) drive(1'b1, 32'h100 + i, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 32'h200 + i, 1'b1, 1'b0);
         n_checks++; if (count !== 4'd3) $display("FAIL b2b_count[%0d]: got %0d required 3", i, count); else n_pass++;
         n_checks++; if (rd_valid !== 1'b1) $display("FAIL b2b_rd_valid[%0d]: got %b required 1", i, rd_valid); else n_pass++;
         n_checks++; if ({overflow, underflow} !== 2'b00) $display("FAIL b2b_err[%0d]: got %b%b required 00", i, overflow, underflow); else n_pass++;
      end
      for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (empty !== 1'b1) $display("FAIL b2b_empty: got %b required 1", empty); else n_pass++;
   endtask

   task automatic test_err_clr_priority();
      for (int i = 0; i < DP; i++) drive(1'b1, 32'hE0 + i, 1'b0, 1'b0);
      drive(1'b1, 32'hEE, 1'b0, 1'b1);
      n_checks++; if (overflow !== 1'b1) $display("FAIL prio_overflow: got %b required 1", overflow); else n_pass++;
      drive(1'b0, '0, 1'b0, 1'b1);
      n_checks++; if (overflow !== 1'b0) $display("FAIL prio_ovf_clear: got %b required 0", overflow); else n_pass++;
      for (int i = 0; i < DP; i++) drive(1'b0, '0, 1'b1, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b1);
      n_checks++; if (underflow !== 1'b1) $display("FAIL prio_underflow: got %b required 1", underflow); else n_pass++;
      drive(1'b0, '0, 1'b0, 1'b1);
      n_checks++; if (underflow !== 1'b0) $display("FAIL prio_unf_clear: got %b required 0", underflow); else n_pass++;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < DP; i++) drive(1'b1, 32'hC0 + i, 1'b0, 1'b0);
      drive(1'b1, 32'hCF, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (count !== 4'd5) $display("FAIL mid_count_pre: got %0d required 5", count); else n_pass++;
      do_reset(1'b1, 1'b1);
      n_checks++; if (count !== 4'd0) $display("FAIL mid_count: got %0d required 0", count); else n_pass++;
      n_checks++; if (empty !== 1'b1) $display("FAIL mid_empty: got %b required 1", empty); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL mid_overflow: got %b required 0", overflow); else n_pass++;
      n_checks++; if (underflow !== 1'b0) $display("FAIL mid_underflow: got %b required 0", underflow); else n_pass++;
      n_checks++; if (rd_valid !== 1'b0) $display("FAIL mid_rd_valid: got %b required 0", rd_valid); else n_pass++;
      n_checks++; if (rd_data !== 32'h0) $display("FAIL mid_rd_data: got %h required 0", rd_data); else n_pass++;
      drive(1'b1, 32'hD1, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (empty !== 1'b1) $display("FAIL mid_after_empty: got %b required 1", empty); else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 150; i++) begin
         drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 7) == 0));
         n_checks++; if (count !== 4'(model_q.size())) $display("FAIL rnd_count[%0d]: got %0d required %0d", i, count, model_q.size()); else n_pass++;
         n_checks++; if (full !== (model_q.size() == DP)) $display("FAIL rnd_full[%0d]: got %b", i, full); else n_pass++;
         n_checks++; if (empty !== (model_q.size() == 0)) $display("FAIL rnd_empty[%0d]: got %b", i, empty); else n_pass++;
         n_checks++; if (almost_full !== (model_q.size() >= 6)) $display("FAIL rnd_afull[%0d]: got %b", i, almost_full); else n_pass++;
         n_checks++; if (almost_empty !== (model_q.size() <= 2)) $display("FAIL rnd_aempty[%0d]: got %b", i, almost_empty); else n_pass++;
         n_checks++; if (overflow !== m_ovf) $display("FAIL rnd_overflow[%0d]: got %b required %b", i, overflow, m_ovf); else n_pass++;
         n_checks++; if (underflow !== m_unf) $display("FAIL rnd_underflow[%0d]: got %b required %b", i, underflow, m_unf); else n_pass++;
         n_checks++; if (rd_valid !== m_rd_valid) $display("FAIL rnd_rd_valid[%0d]: got %b required %b", i, rd_valid, m_rd_valid); else n_pass++;
      end
      for (int i = 0; i < DP; i++) drive(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (empty !== 1'b1) $display("FAIL rnd_final_empty: got %b required 1", empty); else n_pass++;
   endtask

   initial begin
      rst     = 1'b1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      err_clr = 1'b0;
      wr_data = '0;
      m_ovf      = 1'b0;
      m_unf      = 1'b0;
      m_rd_valid = 1'b0;
      last_rd    = '0;
      test_reset();
      test_fill();
      test_drain();
      test_full_rw();
      test_empty_rw();
      test_back_to_back();
      test_err_clr_priority();
      test_reset_mid();
      test_random();
      drive(1'b0, '0, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0);
      n_checks++; if (exp_q.size() != 0) $display("FAIL sb_pending: got %0d unread entries required 0", exp_q.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
